// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
// Purpose: drives an Avalon-MM PLL reconfiguration core through a fixed
// write/poll sequence, then waits for the PLL to report a stable lock.
// Ports:
//   refclk, rst         - sole clock, synchronous active-high reset
//   cfg_start, cfg_*    - start request and N/M/C counter words, fractional K
//   mgmt_*              - Avalon-MM master towards the reconfig core
//   pll_locked          - asynchronous lock indication from the PLL
//   busy, done, err,    - sequence status; done is a one-cycle pulse,
//   err_code              err/err_code are sticky (1 = poll limit, 2 = lock timeout)
module pll_reconfig_sequencer #(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned POLL_LIMIT   = 1023
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c,
  input  logic [31:0] cfg_k,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  output logic        mgmt_read,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned TMO_W       = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned POLL_W      = $clog2(POLL_LIMIT + 1);
  localparam int unsigned LOCK_STABLE = 16;
  localparam int unsigned STB_W       = $clog2(LOCK_STABLE);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, WR_M, WR_K, WR_C0, WR_C1, WR_START, RD_STATUS, WAIT_LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [17:0]         n_q, n_d, m_q, m_d, c_q, c_d;
  logic [31:0]         k_q, k_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic                lock_meta_q, lock_sync_q;
  logic [5:0]          addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                write_q, write_d, read_q, read_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  // Only bit0 of the status word carries meaning.
  logic unused_rd_bits_c;
  assign unused_rd_bits_c = ^mgmt_readdata[31:1];

  // Next-state, counters and the bus phase of the state being entered.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    m_d          = m_q;
    c_d          = c_q;
    k_d          = k_q;
    poll_cnt_d   = poll_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    stable_cnt_d = stable_cnt_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    done_d       = 1'b0;
    addr_d       = '0;
    wdata_d      = '0;
    write_d      = 1'b0;
    read_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q is still high during the done cycle, so a start there is ignored
        if (cfg_start && !busy_q) begin
          n_d        = cfg_n;
          m_d        = cfg_m;
          c_d        = cfg_c;
          k_d        = cfg_k;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          poll_cnt_d = '0;
          state_d    = WR_MODE;
        end
      end
      WR_MODE:  if (!mgmt_waitrequest) state_d = WR_N;
      WR_N:     if (!mgmt_waitrequest) state_d = WR_M;
      WR_M:     if (!mgmt_waitrequest) state_d = WR_K;
      WR_K:     if (!mgmt_waitrequest) state_d = WR_C0;
      WR_C0:    if (!mgmt_waitrequest) state_d = WR_C1;
      WR_C1:    if (!mgmt_waitrequest) state_d = WR_START;
      WR_START: if (!mgmt_waitrequest) state_d = RD_STATUS;
      RD_STATUS: begin
        if (!mgmt_waitrequest) begin
          if (mgmt_readdata[0]) begin
            tmo_cnt_d    = '0;
            stable_cnt_d = '0;
            state_d      = WAIT_LOCK;
          end else if ((32'(poll_cnt_q) + 32'd1) >= POLL_LIMIT) begin
            poll_cnt_d = POLL_W'(POLL_LIMIT);
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
          end
        end
      end
      WAIT_LOCK: begin
        // Lock must be seen on LOCK_STABLE consecutive edges; any drop restarts.
        if (lock_sync_q) begin
          if (stable_cnt_q == STB_W'(LOCK_STABLE - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stable_cnt_d = stable_cnt_q + STB_W'(1);
          end
        end else begin
          stable_cnt_d = '0;
        end
        // A lock completing on the timeout edge wins.
        if (state_d == WAIT_LOCK) begin
          if ((32'(tmo_cnt_q) + 32'd1) >= LOCK_TIMEOUT) begin
            tmo_cnt_d  = TMO_W'(LOCK_TIMEOUT);
            err_d      = 1'b1;
            err_code_d = 2'd2;
            state_d    = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs follow the next state, so a stalled state re-drives identical values.
    case (state_d)
      WR_MODE:   begin addr_d = 6'd0; wdata_d = 32'd1;                  write_d = 1'b1; end
      WR_N:      begin addr_d = 6'd3; wdata_d = 32'(n_d);               write_d = 1'b1; end
      WR_M:      begin addr_d = 6'd4; wdata_d = 32'(m_d);               write_d = 1'b1; end
      WR_K:      begin addr_d = 6'd7; wdata_d = k_d;                    write_d = 1'b1; end
      WR_C0:     begin addr_d = 6'd5; wdata_d = {9'd0, 5'd0, c_d};      write_d = 1'b1; end
      WR_C1:     begin addr_d = 6'd5; wdata_d = {9'd0, 5'd1, c_d};      write_d = 1'b1; end
      WR_START:  begin addr_d = 6'd2; wdata_d = 32'd0;                  write_d = 1'b1; end
      RD_STATUS: begin addr_d = 6'd1;                                   read_d  = 1'b1; end
      default:   ;
    endcase

    busy_d = (state_d != IDLE) || done_d;
  end

  // All state, including the two-flop lock synchroniser.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      m_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      poll_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      stable_cnt_q <= '0;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      m_q          <= m_d;
      c_q          <= c_d;
      k_q          <= k_d;
      poll_cnt_q   <= poll_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      lock_meta_q  <= pll_locked;
      lock_sync_q  <= lock_meta_q;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      read_q       <= read_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
  assign mgmt_write     = write_q;
  assign mgmt_read      = read_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb_pll_reconfig_sequencer
// Purpose: directed bench for pll_reconfig_sequencer. An Avalon slave model with
// programmable stalls and status responses logs every completed transfer against
// the transfer list the configuration implies; bus rules are checked each cycle.
module tb_pll_reconfig_sequencer;

  localparam int unsigned LOCK_TIMEOUT = 100;
  localparam int unsigned POLL_LIMIT   = 4;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c = '0;
  logic [31:0] cfg_k = '0;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;
  logic        busy, done, err;
  logic [1:0]  err_code;

  pll_reconfig_sequencer #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .POLL_LIMIT(POLL_LIMIT)) dut (
    .refclk(refclk), .rst(rst), .cfg_start(cfg_start),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_k(cfg_k),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // slave behaviour knobs and per-run observations
  int wait_cycles = 0;
  int ok_after = 0;          // zero-status reads before bit0=1; -1 = never
  int stall = 0;
  int n_reads = 0, n_done = 0, strobe_cycles = 0;
  int entry_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [31:0] last_c1 = '0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_stalled = 1'b0, prev_rst = 1'b1;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Slave model plus per-cycle bus checks, all on the falling edge.
  always @(negedge refclk) begin
    logic strobe;
    logic bit0;
    txn_t e;
    strobe = mgmt_write | mgmt_read;
    bit0   = 1'b0;
    check("rw_exclusive", 32'(mgmt_write & mgmt_read), 32'd0);
    if (!busy) check("idle_strobe_low", 32'(strobe), 32'd0);
    if (done) begin
      check("busy_during_done", 32'(busy), 32'd1);
      n_done++;
      done_cyc = cyc;
    end
    if (prev_done) begin
      check("done_single_cycle", 32'(done), 32'd0);
      check("busy_falls_after_done", 32'(busy), 32'd0);
    end
    if (err && !prev_err) err_cyc = cyc;
    if (prev_stalled && !prev_rst) begin
      check("stall_strobe", {30'd0, mgmt_write, mgmt_read}, {30'd0, prev_wr, prev_rd});
      check("stall_addr", 32'(mgmt_address), 32'(prev_addr));
      check("stall_data", mgmt_writedata, prev_data);
    end
    if (strobe) strobe_cycles++;

    if (strobe && stall < wait_cycles) begin
      mgmt_waitrequest = 1'b1;
      stall++;
    end else begin
      mgmt_waitrequest = 1'b0;
      stall = 0;
    end

    if (strobe && !mgmt_waitrequest && !rst) begin
      if (mgmt_read) begin
        bit0 = (ok_after >= 0) && (n_reads >= ok_after);
        mgmt_readdata    = $urandom();
        mgmt_readdata[0] = bit0;
        n_reads++;
        if (bit0) entry_cyc = cyc + 1;
      end
      if (mgmt_write && mgmt_address == 6'd5 && mgmt_writedata[22:18] == 5'd1)
        last_c1 = mgmt_writedata;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_txn: got wr=%0b addr=%0d data=0x%0h, expected no transfer",
                 mgmt_write, mgmt_address, mgmt_writedata);
      end else begin
        e = exp_q.pop_front();
        check("txn_kind", 32'(mgmt_write), 32'(e.wr));
        check("txn_addr", 32'(mgmt_address), 32'(e.addr));
        if (e.wr) check("txn_data", mgmt_writedata, e.data);
      end
    end

    prev_done    = done;
    prev_err     = err;
    prev_stalled = strobe && mgmt_waitrequest;
    prev_rst     = rst;
    prev_wr      = mgmt_write;
    prev_rd      = mgmt_read;
    prev_addr    = mgmt_address;
    prev_data    = mgmt_writedata;
  end

  // Transfer list implied by one configuration.
  task automatic build_exp(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                           input logic [31:0] k, input int nreads);
    exp_q.push_back('{1'b1, 6'd0, 32'd1});
    exp_q.push_back('{1'b1, 6'd3, 32'(n)});
    exp_q.push_back('{1'b1, 6'd4, 32'(m)});
    exp_q.push_back('{1'b1, 6'd7, k});
    exp_q.push_back('{1'b1, 6'd5, 32'(c)});
    exp_q.push_back('{1'b1, 6'd5, 32'(c) | (32'd1 << 18)});
    exp_q.push_back('{1'b1, 6'd2, 32'd0});
    for (int i = 0; i < nreads; i++) exp_q.push_back('{1'b0, 6'd1, 32'd0});
  endtask

  task automatic clear_stats();
    n_reads = 0; n_done = 0; strobe_cycles = 0;
    entry_cyc = 0; done_cyc = 0; err_cyc = 0; last_c1 = '0;
  endtask

  task automatic start(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                       input logic [31:0] k);
    @(posedge refclk); #1;
    cfg_n = n; cfg_m = m; cfg_c = c; cfg_k = k; cfg_start = 1'b1;
    @(posedge refclk); #1;
    cfg_start = 1'b0;
    @(negedge refclk); #1;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", {30'd0, err_code}, 32'd0);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge refclk); #1;
      if (!busy) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, max_cyc);
  endtask

  task automatic wait_write_addr(input logic [5:0] a, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge refclk); #1;
      if (mgmt_write && mgmt_address == a) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: no write to addr %0d within %0d cycles, expected one", name, a, max_cyc);
  endtask

  task automatic check_status(input string name, input int reads, input int dones,
                              input logic e, input logic [1:0] code);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_reads"}, 32'(n_reads), 32'(reads));
    check({name, "_dones"}, 32'(n_done), 32'(dones));
    check({name, "_err"}, 32'(err), 32'(e));
    check({name, "_err_code"}, 32'(err_code), 32'(code));
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    // reset state, with a start request colliding with the last reset edge
    repeat (3) @(posedge refclk);
    #1 cfg_start = 1'b1;
    @(posedge refclk); #1;
    rst = 1'b0; cfg_start = 1'b0;
    @(negedge refclk); #1;
    check("rst_write", 32'(mgmt_write), 32'd0);
    check("rst_read", 32'(mgmt_read), 32'd0);
    check("rst_addr", 32'(mgmt_address), 32'd0);
    check("rst_wdata", mgmt_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);

    // zero-wait slave, immediate status, PLL already locked
    clear_stats(); wait_cycles = 0; ok_after = 0;
    build_exp(18'h10203, 18'h20A0B, 18'h2A5C3, 32'hDEADBEEF, 1);
    start(18'h10203, 18'h20A0B, 18'h2A5C3, 32'hDEADBEEF);
    wait_idle(200, "basic_idle");
    check_status("basic", 1, 1, 1'b0, 2'd0);
    check("basic_lock_to_done", 32'(done_cyc - entry_cyc), 32'd16);
    check("basic_strobe_cycles", 32'(strobe_cycles), 32'd8);
    check("basic_c1_word", last_c1, 32'h0006A5C3);

    // three wait states on every transfer
    clear_stats(); wait_cycles = 3; ok_after = 0;
    build_exp(18'h3FFFF, 18'h00001, 18'h00000, 32'h80000001, 1);
    start(18'h3FFFF, 18'h00001, 18'h00000, 32'h80000001);
    wait_idle(300, "stall_idle");
    check_status("stall", 1, 1, 1'b0, 2'd0);
    check("stall_strobe_cycles", 32'(strobe_cycles), 32'd32);

    // status never ready: poll limit
    clear_stats(); wait_cycles = 1; ok_after = -1;
    build_exp(18'h00011, 18'h00022, 18'h00033, 32'h00000044, 4);
    start(18'h00011, 18'h00022, 18'h00033, 32'h00000044);
    wait_idle(300, "poll_idle");
    check_status("poll", 4, 0, 1'b1, 2'd1);

    // status ready on the last allowed read
    clear_stats(); wait_cycles = 0; ok_after = 3;
    build_exp(18'h12345, 18'h05432, 18'h1F00F, 32'h0BADF00D, 4);
    start(18'h12345, 18'h05432, 18'h1F00F, 32'h0BADF00D);
    wait_idle(300, "poll_edge_idle");
    check_status("poll_edge", 4, 1, 1'b0, 2'd0);

    // PLL never locks: timeout
    @(posedge refclk); #1 pll_locked = 1'b0;
    repeat (4) @(posedge refclk);
    clear_stats(); wait_cycles = 0; ok_after = 0;
    build_exp(18'h00100, 18'h00200, 18'h00300, 32'h00000400, 1);
    start(18'h00100, 18'h00200, 18'h00300, 32'h00000400);
    wait_idle(400, "tmo_idle");
    check_status("tmo", 1, 0, 1'b1, 2'd2);
    check("tmo_latency", 32'(err_cyc - entry_cyc), 32'd100);
    @(posedge refclk); #1 pll_locked = 1'b1;
    repeat (4) @(posedge refclk);

    // second start and cfg change while WR_M is in flight
    clear_stats(); wait_cycles = 3; ok_after = 0;
    build_exp(18'h0AAAA, 18'h15555, 18'h00F0F, 32'h13579BDF, 1);
    start(18'h0AAAA, 18'h15555, 18'h00F0F, 32'h13579BDF);
    wait_write_addr(6'd4, 60, "restart_wr_m");
    @(posedge refclk); #1;
    cfg_n = 18'h3C3C3; cfg_m = 18'h01234; cfg_c = 18'h2BCDE; cfg_k = 32'hFFFF0000;
    cfg_start = 1'b1;
    @(posedge refclk); #1 cfg_start = 1'b0;
    wait_idle(300, "restart_idle");
    check_status("restart", 1, 1, 1'b0, 2'd0);
    repeat (20) @(posedge refclk);

    // reset while WR_K is stalled, then a fresh run
    clear_stats(); wait_cycles = 6; ok_after = 0;
    build_exp(18'h00ABC, 18'h00DEF, 18'h01111, 32'h22223333, 1);
    start(18'h00ABC, 18'h00DEF, 18'h01111, 32'h22223333);
    wait_write_addr(6'd7, 80, "rst_mid_wr_k");
    @(posedge refclk); #1 rst = 1'b1;
    @(posedge refclk); #1 rst = 1'b0;
    @(negedge refclk); #1;
    check("rst_mid_write", 32'(mgmt_write), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(mgmt_address), 32'd0);
    check("rst_mid_pending", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    repeat (3) @(posedge refclk);
    clear_stats(); wait_cycles = 0; ok_after = 0;
    build_exp(18'h01010, 18'h02020, 18'h03030, 32'h40404040, 1);
    start(18'h01010, 18'h02020, 18'h03030, 32'h40404040);
    wait_idle(200, "rerun_idle");
    check_status("rerun", 1, 1, 1'b0, 2'd0);
    check("rerun_c1_word", last_c1, 32'h00043030);
    repeat (10) @(posedge refclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
